// File: rtl/rd_req_splitter_pkg.sv
// Shared types and constants for the cache-line read request splitter.
package rd_req_splitter_pkg;

    localparam int CL_ADDR_W      = 58;
    localparam int LEN_W          = 6;
    localparam int LEN_ZERO_IS_64 = 64;
    localparam int REMAIN_W       = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } t_rd_split_state;

    // A zero length field encodes the maximum burst of 64 lines.
    function automatic logic [REMAIN_W-1:0] burst_cls(input logic [LEN_W-1:0] len);
        return (len == '0) ? REMAIN_W'(LEN_ZERO_IS_64) : {1'b0, len};
    endfunction

endpackage

// File: rtl/rd_req_splitter_if.sv
// Burst read request handshake between the core TX read port and the splitter.
interface rd_req_splitter_if;
    import rd_req_splitter_pkg::*;

    logic                 cor_tx_rd_valid;
    logic [CL_ADDR_W-1:0] cor_tx_rd_addr;
    logic [LEN_W-1:0]     cor_tx_rd_len;
    logic                 rd_req_ready;

    modport master (
        output cor_tx_rd_valid,
        output cor_tx_rd_addr,
        output cor_tx_rd_len,
        input  rd_req_ready
    );

    modport slave (
        input  cor_tx_rd_valid,
        input  cor_tx_rd_addr,
        input  cor_tx_rd_len,
        output rd_req_ready
    );

endinterface

// File: rtl/rd_credit_counter.sv
// Up/down count of issued-but-unanswered reads with limit compare and sticky underflow.
module rd_credit_counter #(
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] count,
    output logic       credit_ok,
    output logic       underflow_err
);

    logic [7:0] count_q, count_d;
    logic       underflow_q, underflow_d;

    always_comb begin
        count_d     = count_q;
        underflow_d = underflow_q;
        if (inc && !dec) begin
            count_d = count_q + 8'd1;
        end else if (dec && !inc) begin
            // A response with nothing in flight is flagged and the count clamps at zero.
            if (count_q == 8'd0) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= 8'd0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign count         = count_q;
    assign credit_ok     = (count_q < 8'(MAX_OUTSTANDING));
    assign underflow_err = underflow_q;

endmodule

// File: rtl/rd_req_splitter.sv
// Splits multi-line burst reads into single cache-line requests, throttled by
// downstream almostfull and an outstanding-read credit limit.
module rd_req_splitter
    import rd_req_splitter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int TAG_W           = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rd_req_splitter_if.slave     cor_rd,
    input  logic                 spl_tx_rd_almostfull,
    input  logic                 io_rx_rd_valid,
    output logic                 spl_rd_valid,
    output logic [CL_ADDR_W-1:0] spl_rd_addr,
    output logic [TAG_W-1:0]     spl_rd_tag,
    output logic [7:0]           rd_outstanding,
    output logic                 rd_busy,
    output logic                 rd_underflow_err
);

    t_rd_split_state      state_q, state_d;
    logic [CL_ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [REMAIN_W-1:0]  remaining_q, remaining_d;
    logic [TAG_W-1:0]     tag_cnt_q, tag_cnt_d;
    logic                 spl_rd_valid_q, spl_rd_valid_d;
    logic [CL_ADDR_W-1:0] spl_rd_addr_q, spl_rd_addr_d;
    logic [TAG_W-1:0]     spl_rd_tag_q, spl_rd_tag_d;

    logic credit_ok;
    logic issue_en;

    assign issue_en = (state_q == ISSUE) && !spl_tx_rd_almostfull && credit_ok
                      && (remaining_q != '0);

    rd_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk           (clk),
        .reset_n       (reset_n),
        .inc           (issue_en),
        .dec           (io_rx_rd_valid),
        .count         (rd_outstanding),
        .credit_ok     (credit_ok),
        .underflow_err (rd_underflow_err)
    );

    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        remaining_d    = remaining_q;
        tag_cnt_d      = tag_cnt_q;
        spl_rd_valid_d = issue_en;
        spl_rd_addr_d  = spl_rd_addr_q;
        spl_rd_tag_d   = spl_rd_tag_q;

        case (state_q)
            IDLE: begin
                if (cor_rd.cor_tx_rd_valid) begin
                    state_d     = ISSUE;
                    cur_addr_d  = cor_rd.cor_tx_rd_addr;
                    remaining_d = burst_cls(cor_rd.cor_tx_rd_len);
                end
            end
            ISSUE: begin
                if (issue_en) begin
                    spl_rd_addr_d = cur_addr_q;
                    spl_rd_tag_d  = tag_cnt_q;
                    cur_addr_d    = cur_addr_q + CL_ADDR_W'(1);
                    tag_cnt_d     = tag_cnt_q + TAG_W'(1);
                    remaining_d   = remaining_q - REMAIN_W'(1);
                    // Last line of the burst: ready reappears while it is on the bus.
                    if (remaining_q == REMAIN_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cur_addr_q     <= '0;
            remaining_q    <= '0;
            tag_cnt_q      <= '0;
            spl_rd_valid_q <= 1'b0;
            spl_rd_addr_q  <= '0;
            spl_rd_tag_q   <= '0;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            remaining_q    <= remaining_d;
            tag_cnt_q      <= tag_cnt_d;
            spl_rd_valid_q <= spl_rd_valid_d;
            spl_rd_addr_q  <= spl_rd_addr_d;
            spl_rd_tag_q   <= spl_rd_tag_d;
        end
    end

    assign cor_rd.rd_req_ready = (state_q == IDLE);
    assign spl_rd_valid        = spl_rd_valid_q;
    assign spl_rd_addr         = spl_rd_addr_q;
    assign spl_rd_tag          = spl_rd_tag_q;
    assign rd_busy             = (state_q == ISSUE) || (rd_outstanding != 8'd0);

endmodule

// File: tb/tb_rd_req_splitter.sv
// Directed bench: table of bursts on a 64-credit splitter, plus hand sequences
// for credit limiting, same-cycle issue/response, underflow and mid-burst reset.
`timescale 1ns/1ps
module tb_rd_req_splitter;
    import rd_req_splitter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b1;

    rd_req_splitter_if ifa();
    rd_req_splitter_if ifb();

    logic        af_a, rx_a, v_a, busy_a, err_a;
    logic [57:0] addr_a;
    logic [7:0]  tag_a, out_a;
    logic        af_b, rx_b, v_b, busy_b, err_b;
    logic [57:0] addr_b;
    logic [7:0]  tag_b, out_b;

    rd_req_splitter #(.MAX_OUTSTANDING(64), .TAG_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .cor_rd(ifa),
        .spl_tx_rd_almostfull(af_a), .io_rx_rd_valid(rx_a),
        .spl_rd_valid(v_a), .spl_rd_addr(addr_a), .spl_rd_tag(tag_a),
        .rd_outstanding(out_a), .rd_busy(busy_a), .rd_underflow_err(err_a)
    );

    rd_req_splitter #(.MAX_OUTSTANDING(4), .TAG_W(8)) dut4 (
        .clk(clk), .reset_n(reset_n), .cor_rd(ifb),
        .spl_tx_rd_almostfull(af_b), .io_rx_rd_valid(rx_b),
        .spl_rd_valid(v_b), .spl_rd_addr(addr_b), .spl_rd_tag(tag_b),
        .rd_outstanding(out_b), .rd_busy(busy_b), .rd_underflow_err(err_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [57:0] addr;
        logic [5:0]  len;
        int          af_s;
        int          af_e;
        int          exp_n;
        int          exp_last;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    logic [7:0]  exp_tag_a;
    logic [7:0]  exp_tag_b;
    logic [57:0] exp_addr;
    int          n, last_k, w, cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // addr, len, stall window (cycles relative to acceptance), pulses, cycle of last pulse
        vecs[0] = '{58'h100,               6'd4,  0, 0,  4,  4};
        vecs[1] = '{58'h200,               6'd0,  0, 0, 64, 64};
        vecs[2] = '{58'h300,               6'd8,  2, 5,  8, 12};
        vecs[3] = '{58'h3FFFFFFFFFFFFFE,   6'd3,  0, 0,  3,  3};
        vecs[4] = '{58'h80,                6'd2,  1, 3,  2,  5};
        vecs[5] = '{58'h40,                6'd63, 0, 0, 63, 63};
        vecs[6] = '{58'h50,                6'd0,  0, 0, 64, 64};
        vecs[7] = '{58'h60,                6'd60, 0, 0, 60, 60};

        ifa.cor_tx_rd_valid = 1'b0; ifa.cor_tx_rd_addr = '0; ifa.cor_tx_rd_len = '0;
        ifb.cor_tx_rd_valid = 1'b0; ifb.cor_tx_rd_addr = '0; ifb.cor_tx_rd_len = '0;
        af_a = 1'b0; rx_a = 1'b0; af_b = 1'b0; rx_b = 1'b0;
        exp_tag_a = 8'd0; exp_tag_b = 8'd0;

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   ifa.rd_req_ready, 1);
        chk("rst_valid",   v_a, 0);
        chk("rst_addr",    addr_a, 0);
        chk("rst_tag",     tag_a, 0);
        chk("rst_outst",   out_a, 0);
        chk("rst_busy",    busy_a, 0);
        chk("rst_err",     err_a, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", v_a, 0);

        for (int v = 0; v < NV; v++) begin
            w = 0;
            while (!ifa.rd_req_ready && w < 20) begin @(negedge clk); w++; end
            chk("ready_before_burst", ifa.rd_req_ready, 1);
            ifa.cor_tx_rd_valid = 1'b1;
            ifa.cor_tx_rd_addr  = vecs[v].addr;
            ifa.cor_tx_rd_len   = vecs[v].len;
            @(negedge clk);
            ifa.cor_tx_rd_valid = 1'b0;
            chk("accepted", ifa.rd_req_ready, 0);
            exp_addr = vecs[v].addr; n = 0; last_k = 0;
            for (int k = 1; k <= 200 && n < vecs[v].exp_n; k++) begin
                af_a = (k >= vecs[v].af_s) && (k <= vecs[v].af_e);
                @(negedge clk);
                if (af_a) chk("stall_quiet", v_a, 0);
                if (v_a) begin
                    chk("burst_addr", addr_a, exp_addr);
                    chk("burst_tag",  tag_a,  exp_tag_a);
                    exp_addr  = exp_addr + 58'd1;
                    exp_tag_a = exp_tag_a + 8'd1;
                    n++;
                    last_k = k;
                    chk("ready_vs_last", ifa.rd_req_ready, (n == vecs[v].exp_n));
                end
            end
            af_a = 1'b0;
            chk("pulse_count", n, vecs[v].exp_n);
            chk("last_cycle",  last_k, vecs[v].exp_last);
            chk("outstanding", out_a, vecs[v].exp_n);
            @(negedge clk);
            chk("no_extra_pulse", v_a, 0);
            chk("busy_with_outst", busy_a, 1);
            rx_a = 1'b1;
            repeat (vecs[v].exp_n) @(negedge clk);
            rx_a = 1'b0;
            chk("drained", out_a, 0);
            chk("idle_busy", busy_a, 0);
            chk("no_underflow", err_a, 0);
            $display("burst %0d addr=0x%0h len=%0d pulses=%0d last_cycle=%0d", v,
                     vecs[v].addr, vecs[v].len, n, last_k);
        end

        // Credit limit of 4, len=8, responses only released one at a time
        ifb.cor_tx_rd_valid = 1'b1; ifb.cor_tx_rd_addr = 58'h500; ifb.cor_tx_rd_len = 6'd8;
        @(negedge clk);
        ifb.cor_tx_rd_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (v_b) begin
                chk("lim_addr", addr_b, 58'h500 + 58'(n));
                chk("lim_tag",  tag_b,  exp_tag_b);
                exp_tag_b = exp_tag_b + 8'd1;
                n++;
            end
        end
        chk("lim_stop_count", n, 4);
        chk("lim_outst", out_b, 4);
        for (int r = 0; r < 4; r++) begin
            rx_b = 1'b1;
            @(negedge clk);
            rx_b = 1'b0;
            chk("lim_released", out_b, 3);
            cnt = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (v_b) begin
                    chk("lim_addr", addr_b, 58'h500 + 58'(n));
                    chk("lim_tag",  tag_b,  exp_tag_b);
                    exp_tag_b = exp_tag_b + 8'd1;
                    n++; cnt++;
                end
            end
            chk("one_per_credit", cnt, 1);
            chk("lim_outst_refill", out_b, 4);
            $display("credit release %0d issued=%0d", r, n);
        end
        chk("lim_total", n, 8);
        chk("lim_ready", ifb.rd_req_ready, 1);
        rx_b = 1'b1;
        repeat (4) @(negedge clk);
        rx_b = 1'b0;
        chk("lim_drained", out_b, 0);

        // Issue and response in the same cycle at outstanding == 3
        ifb.cor_tx_rd_valid = 1'b1; ifb.cor_tx_rd_addr = 58'h600; ifb.cor_tx_rd_len = 6'd4;
        @(negedge clk);
        ifb.cor_tx_rd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("same_pre_valid", v_b, 1);
        end
        chk("same_pre_outst", out_b, 3);
        rx_b = 1'b1;
        @(negedge clk);
        rx_b = 1'b0;
        chk("same_valid", v_b, 1);
        chk("same_addr",  addr_b, 58'h603);
        chk("same_outst", out_b, 3);
        rx_b = 1'b1;
        repeat (3) @(negedge clk);
        rx_b = 1'b0;
        chk("same_drained", out_b, 0);
        chk("same_no_underflow", err_b, 0);
        $display("same-cycle issue/response outstanding=%0d", out_b);

        // Underflow: response with nothing outstanding
        rx_a = 1'b1;
        @(negedge clk);
        rx_a = 1'b0;
        chk("uf_err", err_a, 1);
        chk("uf_outst", out_a, 0);
        @(negedge clk);
        chk("uf_sticky", err_a, 1);
        $display("underflow err=%0d outstanding=%0d", err_a, out_a);

        // Reset in the middle of a burst after three issues
        ifa.cor_tx_rd_valid = 1'b1; ifa.cor_tx_rd_addr = 58'h7; ifa.cor_tx_rd_len = 6'd10;
        @(negedge clk);
        ifa.cor_tx_rd_valid = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        chk("mid_valid", v_a, 1);
        chk("mid_outst", out_a, 3);
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_valid", v_a, 0);
        chk("mrst_addr",  addr_a, 0);
        chk("mrst_tag",   tag_a, 0);
        chk("mrst_outst", out_a, 0);
        chk("mrst_busy",  busy_a, 0);
        chk("mrst_err",   err_a, 0);
        chk("mrst_ready", ifa.rd_req_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        exp_tag_a = 8'd0;
        @(negedge clk);
        chk("mrst_first_cycle_quiet", v_a, 0);
        chk("mrst_abandoned_busy", busy_a, 0);
        ifa.cor_tx_rd_valid = 1'b1; ifa.cor_tx_rd_addr = 58'h900; ifa.cor_tx_rd_len = 6'd2;
        @(negedge clk);
        ifa.cor_tx_rd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_rst_burst_valid", v_a, 1);
            chk("post_rst_burst_addr",  addr_a, 58'h900 + 58'(k));
            chk("post_rst_burst_tag",   tag_a, exp_tag_a);
            exp_tag_a = exp_tag_a + 8'd1;
        end
        $display("mid-burst reset then burst addr=0x900 tags restart at 0");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
